// File: rtl/fifo_multi.sv
// fifo_multi: CHANNELS independent FIFOs sharing one memory array, one
// write port and one read port, each steered by a per-request channel.
// Ports:
//   clk_i, arst_i            clock, async active-high reset
//   flush_i[CHANNELS]        per-channel synchronous flush
//   data_i, wr_ch_i, wrreq_i write port
//   rd_ch_i, rdreq_i         read port
//   q_o, q_valid_o           read data (showahead or registered)
//   usedw_o                  per-channel fill, (AWIDTH+1) bits each
//   empty_o, full_o, almost_full_o, almost_empty_o  per-channel flags
//   ovf_o, udf_o             sticky error flags, only with FIFO_MULTI_ERR_EN
module fifo_multi #(
  parameter int DWIDTH             = 32,
  parameter int AWIDTH             = 4,
  parameter int CHANNELS           = 4,
  parameter int SHOWAHEAD          = 1,
  parameter int ALMOST_FULL_VALUE  = 12,
  parameter int ALMOST_EMPTY_VALUE = 4
) (
  input  logic                            clk_i,
  input  logic                            arst_i,
  input  logic [CHANNELS-1:0]             flush_i,
  input  logic [DWIDTH-1:0]               data_i,
  input  logic [$clog2(CHANNELS)-1:0]     wr_ch_i,
  input  logic                            wrreq_i,
  input  logic [$clog2(CHANNELS)-1:0]     rd_ch_i,
  input  logic                            rdreq_i,
  output logic [DWIDTH-1:0]               q_o,
  output logic                            q_valid_o,
  output logic [CHANNELS*(AWIDTH+1)-1:0]  usedw_o,
  output logic [CHANNELS-1:0]             empty_o,
  output logic [CHANNELS-1:0]             full_o,
  output logic [CHANNELS-1:0]             almost_full_o,
  output logic [CHANNELS-1:0]             almost_empty_o,
  output logic [CHANNELS-1:0]             ovf_o,
  output logic [CHANNELS-1:0]             udf_o
);

  localparam int CWIDTH = $clog2(CHANNELS);
  localparam int D      = 2 ** AWIDTH;
  localparam int MW     = CWIDTH + AWIDTH;

  logic [DWIDTH-1:0] mem [CHANNELS*D];

  logic [AWIDTH-1:0] wr_ptr [CHANNELS];
  logic [AWIDTH-1:0] rd_ptr [CHANNELS];
  logic [AWIDTH:0]   count  [CHANNELS];

  logic [CHANNELS-1:0] wr_oh;
  logic [CHANNELS-1:0] rd_oh;
  logic [CHANNELS-1:0] wr_go;
  logic [CHANNELS-1:0] rd_go;

  logic [MW-1:0]     wr_addr;
  logic [MW-1:0]     rd_addr;
  logic [DWIDTH-1:0] head;
  logic              head_vld;

  always_comb begin
    wr_oh = '0;
    rd_oh = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      wr_oh[c] = (wr_ch_i == CWIDTH'(c));
      rd_oh[c] = (rd_ch_i == CWIDTH'(c));
    end
  end

  // A flushed channel swallows both requests.
  assign wr_go = wr_oh & ~full_o & ~flush_i
               & {CHANNELS{wrreq_i}};
  assign rd_go = rd_oh & ~empty_o & ~flush_i
               & {CHANNELS{rdreq_i}};

  assign wr_addr = {wr_ch_i, wr_ptr[wr_ch_i]};
  assign rd_addr = {rd_ch_i, rd_ptr[rd_ch_i]};

  always_comb begin
    usedw_o        = '0;
    empty_o        = '0;
    full_o         = '0;
    almost_full_o  = '0;
    almost_empty_o = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      usedw_o[c*(AWIDTH+1) +: AWIDTH+1] = count[c];
      empty_o[c] = (count[c] == '0);
      full_o[c]  = (count[c] == (AWIDTH+1)'(D));
      almost_full_o[c] =
        (int'(count[c]) >= ALMOST_FULL_VALUE);
      almost_empty_o[c] =
        (int'(count[c]) < ALMOST_EMPTY_VALUE);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (flush_i[c]) begin
          wr_ptr[c] <= '0;
          rd_ptr[c] <= '0;
          count[c]  <= '0;
        end else begin
          if (wr_go[c])
            wr_ptr[c] <= wr_ptr[c] + 1'b1;
          if (rd_go[c])
            rd_ptr[c] <= rd_ptr[c] + 1'b1;
          if (wr_go[c] && !rd_go[c])
            count[c] <= count[c] + 1'b1;
          else if (!wr_go[c] && rd_go[c])
            count[c] <= count[c] - 1'b1;
        end
      end
    end
  end

  // Storage is not reset; counts alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (|wr_go)
      mem[wr_addr] <= data_i;
  end

  assign head     = mem[rd_addr];
  assign head_vld = |(rd_oh & ~empty_o);

  generate
    if (SHOWAHEAD != 0) begin : g_sa
      // Masked so q_o is 0 out of reset, before memory is written.
      assign q_o       = head_vld ? head : '0;
      assign q_valid_o = head_vld;
    end else begin : g_reg
      always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
          q_o       <= '0;
          q_valid_o <= 1'b0;
        end else begin
          q_valid_o <= |rd_go;
          if (|rd_go)
            q_o <= head;
        end
      end
    end
  endgenerate

`ifdef FIFO_MULTI_ERR_EN
  logic [CHANNELS-1:0] ovf_q;
  logic [CHANNELS-1:0] udf_q;

  // Requests to a flushed channel never raise an error.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (flush_i[c]) begin
          ovf_q[c] <= 1'b0;
          udf_q[c] <= 1'b0;
        end else begin
          if (wrreq_i && wr_oh[c] && full_o[c])
            ovf_q[c] <= 1'b1;
          if (rdreq_i && rd_oh[c] && empty_o[c])
            udf_q[c] <= 1'b1;
        end
      end
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`else
  assign ovf_o = '0;
  assign udf_o = '0;
`endif

endmodule

// File: doc/fifo_multi.md
# fifo_multi

Multi-channel synchronous FIFO: CHANNELS independent queues, each 2**AWIDTH words deep, sharing one memory array, with one write port and one read port per cycle. Each port selects its channel per request. Per-channel fill level, flags and flush. Used wherever several logical streams share one buffer, for example per-queue buffering ahead of an arbiter.

## Interface
- DWIDTH, 32: data width.
- AWIDTH, 4: log2 of per-channel depth. Depth D = 2**AWIDTH.
- CHANNELS, 4: number of queues, at least 2. CWIDTH = $clog2(CHANNELS) is derived internally.
- SHOWAHEAD, 1: 1 = head word visible on q_o without a read; 0 = registered read data.
- ALMOST_FULL_VALUE, 12: almost_full threshold.
- ALMOST_EMPTY_VALUE, 4: almost_empty threshold.

Ports:
- clk_i  in  1  sole clock; all logic on the rising edge.
- arst_i  in  1  asynchronous, active-high reset.
- flush_i  in  CHANNELS  synchronous per-channel flush.
- data_i  in  DWIDTH  write data.
- wr_ch_i  in  CWIDTH  write channel select.
- wrreq_i  in  1  write request.
- rd_ch_i  in  CWIDTH  read channel select.
- rdreq_i  in  1  read request.
- q_o  out  DWIDTH  read data.
- q_valid_o  out  1  q_o holds valid data.
- usedw_o  out  CHANNELS*(AWIDTH+1)  per-channel fill level, flattened; channel c is at [c*(AWIDTH+1) +: AWIDTH+1].
- empty_o, full_o, almost_full_o, almost_empty_o  out  CHANNELS each  per-channel flags.
- ovf_o, udf_o  out  CHANNELS each  sticky overflow and underflow flags.

## Operation
- Memory has CHANNELS*D entries, addressed {channel, ptr}. Each channel has its own wr_ptr and rd_ptr (AWIDTH bits, natural wrap at D) and its own count (AWIDTH+1 bits).
- Write acceptance: wrreq_i && !full_o[wr_ch_i] && !flush_i[wr_ch_i]. An accepted write stores data_i at {wr_ch_i, wr_ptr} and increments wr_ptr.
- Read acceptance: rdreq_i && !empty_o[rd_ch_i] && !flush_i[rd_ch_i]. An accepted read increments rd_ptr.
- Count update per channel: +1 on accepted write only, −1 on accepted read only, unchanged when both are accepted on the same channel.
- Reads and writes on different channels are fully independent.
- Flags, all derived from the registered count:
  - empty = (count == 0).
  - full = (count == D).
  - almost_full = (count >= ALMOST_FULL_VALUE).
  - almost_empty = (count < ALMOST_EMPTY_VALUE).
- Full channel, read and write on it in the same cycle: the write is rejected. Empty channel, read and write on it in the same cycle: the read is rejected and the write is accepted.
- Flush: the flush_i[c] edge sets channel c pointers and count to 0. Requests to c in that cycle are dropped and set no error flags. Flushing c does not affect any other channel.
- SHOWAHEAD=1: q_o = mem[{rd_ch_i, rd_ptr[rd_ch_i]}] combinationally; q_valid_o = !empty_o[rd_ch_i].
- SHOWAHEAD=0: on an accepted read, q_o is loaded with the head word and q_valid_o is 1 the next cycle. Otherwise q_valid_o = 0 and q_o holds its value.
- Reset values: all counts, pointers, usedw_o, full_o, almost_full_o, ovf_o, udf_o = 0; empty_o = all ones; almost_empty_o = all ones when ALMOST_EMPTY_VALUE > 0; q_o = 0; q_valid_o = 0.
- arst_i asserted mid-operation discards all contents immediately.

## Timing
- Write to flag/usedw latency: 1 cycle. A write at edge N makes the data readable and updates usedw at edge N+1.
- SHOWAHEAD=1: the first word written to an empty channel appears on q_o 1 cycle after the write edge.
- SHOWAHEAD=0: read latency is 1 cycle from the accepted read to q_o/q_valid_o.
- Back-to-back reads or writes are sustained at 1 per cycle per port.
- Memory write and head read of the same address in the same cycle return the old data.

## Configuration
- FIFO_MULTI_ERR_EN defined:
  - ovf_o[c] is set by a wrreq_i to channel c that is rejected because c is full.
  - udf_o[c] is set by a rdreq_i to channel c that is rejected because c is empty.
  - Both are sticky and cleared only by arst_i or flush_i[c].
- FIFO_MULTI_ERR_EN undefined: ovf_o and udf_o are tied to 0 and no error logic is synthesised.

## Test plan
- Reset, then idle -> empty_o = 4'b1111, usedw_o all 0, q_valid_o = 0.
- Write 16 words 0..15 to ch2 (AWIDTH=4), one more write -> full_o[2] = 1, usedw ch2 = 16, ovf_o[2] = 1 (with macro), and ch2 data intact.
- Interleave writes ch0 (A0..A3) and ch1 (B0..B3), then read ch1 four times -> q_o = B0..B3 in order; ch0 usedw stays 4.
- Simultaneous read and write on ch3 holding 5 words, for 10 cycles -> usedw ch3 stays 5 and data order is preserved across pointer wrap.
- Read from empty ch0 with a same-cycle write to ch0 -> read rejected, udf_o[0] = 1 (with macro), usedw ch0 = 1.
- Fill ch1 to 8, assert flush_i[1] with a concurrent write to ch1 -> usedw ch1 = 0, empty_o[1] = 1, no flags set, other channels unchanged.
